dispatch_stage: RTL
===================

Name: dispatch_stage

Overview:
- Parametrised dual-slot (A older, B younger) dispatch stage between the decoder and the distributed reservation stations (complex, simple and FP classes).
- Buffers one decoded pair in a stage register with a valid/ready handshake.
- Picks free RS entries by priority and allocates in-order ROB tags from an internal tail pointer and occupancy counter.
- Supports partial dispatch (A goes, B waits), ROB retire accounting and flush.

Parameters:
DATA_W, 114, payload width forwarded to the RS (decoded word minus dispatch control)
N_CPLX, 2, complex RS entries
N_SIMPLE, 2, simple RS entries
N_FP, 2, FP RS entries
ROB_DEPTH, 16, ROB entries (power of two)
SIMPLE_TO_CPLX, 1, 1 = simple ops may fall back to complex RS entries

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoder offers a pair
in_ready  out  1  stage accepts the pair this cycle
inst_a_vld / inst_b_vld  in  1 each  slot holds a real instruction
inst_a_ctrl / inst_b_ctrl  in  2 each  dispatch class: 00 none, 01 complex, 10 fp, 11 simple
inst_a_data / inst_b_data  in  DATA_W each  payload
cplx_empty  in  N_CPLX  per-entry free bits
simple_empty  in  N_SIMPLE  per-entry free bits
fp_empty  in  N_FP  per-entry free bits
commit_cnt  in  2  ROB entries retired this cycle (0..2)
flush  in  1  squash staged pair and all allocated ROB entries
wr_a_en / wr_b_en  out  1 each  RS write strobe for each slot
wr_a_cls / wr_b_cls  out  2 each  target class (01 complex, 10 fp, 11 simple)
wr_a_idx / wr_b_idx  out  $clog2(max N) each  entry index within the class
wr_a_rob / wr_b_rob  out  $clog2(ROB_DEPTH) each  ROB tag
wr_a_data / wr_b_data  out  DATA_W each  payload
rob_tail  out  $clog2(ROB_DEPTH)  next tag to allocate
rob_count  out  $clog2(ROB_DEPTH)+1  allocated entries
stall_a / stall_b  out  1 each  staged slot pending and blocked this cycle

Behaviour:
- Reset values: stage empty, rob_tail=0, internal head=0, rob_count=0. All wr_* are 0 and in_ready=1 while reset is asserted.
- Stage register holds per-slot pending bits: pend_a = inst_a_vld & ctrl!=00, and likewise for B. Class-00 slots never pend and consume no ROB tag.
- Pair capture: on an edge with in_valid & in_ready. Dispatch happens in the following cycle, so latency is 1 cycle. wr_* are combinational from stage state; the RS captures them on that cycle's edge.
- in_ready = no pending slot, or every pending slot dispatches this cycle. Back-to-back pairs then sustain 2 instructions/cycle.
- Entry selection for A:
  - complex class: lowest free cplx_empty index.
  - fp class: lowest free fp_empty index.
  - simple class: lowest free simple_empty index; if none and SIMPLE_TO_CPLX=1, lowest free cplx_empty index.
- Entry selection for B: same rules, but on the empty vectors with A's chosen entry masked out.
- ROB check: A needs rob_count < ROB_DEPTH; B needs one more free entry if A also dispatches this cycle.
- In-order rule: B never dispatches while A is pending and blocked. If A dispatches and B is blocked, pend_a clears and B retries on later cycles.
- Tags: the first dispatching slot takes rob_tail, the second takes rob_tail+1. Tags wrap modulo ROB_DEPTH.
- rob_tail advances by the number dispatched (0..2).
- rob_count_next = rob_count + dispatched − commit_cnt. The internal head advances by commit_cnt. commit_cnt > rob_count is illegal; guard it with an assertion.
- Same-cycle commit and dispatch: the ROB check uses the registered rob_count only, with no bypass of commit_cnt.
- flush (highest priority, takes effect on the edge): pending bits clear, wr_* are forced to 0 that cycle, rob_count←0, rob_tail←head+commit_cnt, and no capture that cycle.
- stall_a / stall_b = pending & not dispatching, for hazard and performance counters.
- Async reset asserted mid-dispatch discards the staged pair and forces all write strobes low immediately.

Decomposition:
- Shared package: class encodings (CLS_NONE/CPLX/FP/SIMPLE) and ROB tag width function.
- One natural sub-module, rs_pick_lowest (parametrised width; free vector and mask in, found + index out), instantiated once per class per slot.

Test Plan:
- Back-to-back pairs, all RS free, ROB empty, A=simple and B=simple on consecutive cycles → cycle 1: wr_a simple idx0 rob0, wr_b simple idx1 rob1, in_ready=1 every cycle. Repeat for pairs from cycles 2 and 3: each pair takes the next two tags, rob_count 2,4,6.
- Simple fallback: simple_empty=00, cplx_empty=11, A=simple, B=complex → A to complex idx0, B to complex idx1. Then cplx_empty=01, A=simple → A complex idx0, B stalls, in_ready=0.
- Partial dispatch: fp_empty=01, A=fp, B=fp → A fp idx0 rob0, stall_b=1. Release fp_empty=10 next cycle → B fp idx1 rob1, in_ready=1.
- ROB full and wrap: preload rob_count=15, rob_tail=15, offer A,B → A gets tag 15, B stalls. Then commit_cnt=2 → B gets tag 0 (wrap), rob_count ends 15.
- Flush while B is pending → wr_b_en=0, rob_count=0 next cycle, rob_tail equals head, and a new pair is accepted the following cycle.
- Async reset asserted with wr_a_en=1 → wr_a_en drops without a clock, rob_tail=0 after release.

Source files
------------

// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage: RS class encodings and index/tag
// width helpers.
package dispatch_stage_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'b00,
        CLS_CPLX   = 2'b01,
        CLS_FP     = 2'b10,
        CLS_SIMPLE = 2'b11
    } cls_e;

    function automatic int tag_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int idx_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dispatch_stage_pick.sv
// Lowest-index free-entry finder for one RS class; masked bits are treated as
// already taken.
module rs_pick_lowest #(
    parameter int W     = 2,
    parameter int IDX_W = 1
) (
    input  logic [W-1:0]     free_i,
    input  logic [W-1:0]     mask_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [W-1:0] avail;

    assign avail   = free_i & ~mask_i;
    assign found_o = |avail;

    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (avail[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dual-slot dispatch stage: stages one decoded pair, picks RS entries by
// priority and hands out in-order ROB tags.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int DATA_W         = 114,
    parameter int N_CPLX         = 2,
    parameter int N_SIMPLE       = 2,
    parameter int N_FP           = 2,
    parameter int ROB_DEPTH      = 16,
    parameter int SIMPLE_TO_CPLX = 1,
    localparam int IDX_W = idx_w(N_CPLX, N_SIMPLE, N_FP),
    localparam int TAG_W = tag_w(ROB_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                inst_a_vld,
    input  logic                inst_b_vld,
    input  logic [1:0]          inst_a_ctrl,
    input  logic [1:0]          inst_b_ctrl,
    input  logic [DATA_W-1:0]   inst_a_data,
    input  logic [DATA_W-1:0]   inst_b_data,
    input  logic [N_CPLX-1:0]   cplx_empty,
    input  logic [N_SIMPLE-1:0] simple_empty,
    input  logic [N_FP-1:0]     fp_empty,
    input  logic [1:0]          commit_cnt,
    input  logic                flush,
    output logic                wr_a_en,
    output logic                wr_b_en,
    output logic [1:0]          wr_a_cls,
    output logic [1:0]          wr_b_cls,
    output logic [IDX_W-1:0]    wr_a_idx,
    output logic [IDX_W-1:0]    wr_b_idx,
    output logic [TAG_W-1:0]    wr_a_rob,
    output logic [TAG_W-1:0]    wr_b_rob,
    output logic [DATA_W-1:0]   wr_a_data,
    output logic [DATA_W-1:0]   wr_b_data,
    output logic [TAG_W-1:0]    rob_tail,
    output logic [TAG_W:0]      rob_count,
    output logic                stall_a,
    output logic                stall_b
);

    localparam int CNT_W = TAG_W + 1;
    localparam logic [N_CPLX-1:0]   ONE_C = N_CPLX'(1);
    localparam logic [N_SIMPLE-1:0] ONE_S = N_SIMPLE'(1);
    localparam logic [N_FP-1:0]     ONE_F = N_FP'(1);

    typedef struct packed {
        logic             ok;
        cls_e             cls;
        logic [IDX_W-1:0] idx;
    } sel_t;

    logic              pend_a_q, pend_b_q, pend_a_d, pend_b_d;
    cls_e              cls_a_q, cls_b_q;
    logic [DATA_W-1:0] data_a_q, data_b_q;
    logic [TAG_W-1:0]  tail_q, head_q, tail_d, head_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ca_f, sa_f, fa_f, cb_f, sb_f, fb_f;
    logic [IDX_W-1:0]  ca_i, sa_i, fa_i, cb_i, sb_i, fb_i;
    logic [N_CPLX-1:0]   cplx_mask_b;
    logic [N_SIMPLE-1:0] simple_mask_b;
    logic [N_FP-1:0]     fp_mask_b;
    sel_t              sel_a, sel_b;
    logic              disp_a, disp_b, a_block, rob_ok_a, rob_ok_b, capture;
    logic [1:0]        ndisp;

    // Simple ops fall back to a complex entry only when no simple entry is free.
    function automatic sel_t select(input cls_e c,
                                    input logic cf, input logic [IDX_W-1:0] ci,
                                    input logic sf, input logic [IDX_W-1:0] si,
                                    input logic ff, input logic [IDX_W-1:0] fi);
        sel_t s;
        s = '{ok: 1'b0, cls: CLS_NONE, idx: '0};
        case (c)
            CLS_CPLX: s = '{ok: cf, cls: CLS_CPLX, idx: ci};
            CLS_FP:   s = '{ok: ff, cls: CLS_FP, idx: fi};
            CLS_SIMPLE: begin
                if (sf)                            s = '{ok: 1'b1, cls: CLS_SIMPLE, idx: si};
                else if (SIMPLE_TO_CPLX != 0 && cf) s = '{ok: 1'b1, cls: CLS_CPLX, idx: ci};
            end
            default: s = '{ok: 1'b0, cls: CLS_NONE, idx: '0};
        endcase
        return s;
    endfunction

    rs_pick_lowest #(.W(N_CPLX),   .IDX_W(IDX_W)) u_cplx_a   (.free_i(cplx_empty),   .mask_i('0),            .found_o(ca_f), .idx_o(ca_i));
    rs_pick_lowest #(.W(N_SIMPLE), .IDX_W(IDX_W)) u_simple_a (.free_i(simple_empty), .mask_i('0),            .found_o(sa_f), .idx_o(sa_i));
    rs_pick_lowest #(.W(N_FP),     .IDX_W(IDX_W)) u_fp_a     (.free_i(fp_empty),     .mask_i('0),            .found_o(fa_f), .idx_o(fa_i));
    rs_pick_lowest #(.W(N_CPLX),   .IDX_W(IDX_W)) u_cplx_b   (.free_i(cplx_empty),   .mask_i(cplx_mask_b),   .found_o(cb_f), .idx_o(cb_i));
    rs_pick_lowest #(.W(N_SIMPLE), .IDX_W(IDX_W)) u_simple_b (.free_i(simple_empty), .mask_i(simple_mask_b), .found_o(sb_f), .idx_o(sb_i));
    rs_pick_lowest #(.W(N_FP),     .IDX_W(IDX_W)) u_fp_b     (.free_i(fp_empty),     .mask_i(fp_mask_b),     .found_o(fb_f), .idx_o(fb_i));

    assign sel_a = select(cls_a_q, ca_f, ca_i, sa_f, sa_i, fa_f, fa_i);
    assign sel_b = select(cls_b_q, cb_f, cb_i, sb_f, sb_i, fb_f, fb_i);

    // ROB room is judged on the registered count; same-cycle commits free space next cycle.
    assign rob_ok_a = count_q < CNT_W'(ROB_DEPTH);
    assign rob_ok_b = disp_a ? (count_q < CNT_W'(ROB_DEPTH - 1)) : rob_ok_a;
    assign disp_a   = pend_a_q & sel_a.ok & rob_ok_a & ~flush;
    assign a_block  = pend_a_q & ~disp_a;
    assign disp_b   = pend_b_q & ~a_block & sel_b.ok & rob_ok_b & ~flush;
    assign ndisp    = {1'b0, disp_a} + {1'b0, disp_b};

    assign cplx_mask_b   = (disp_a && sel_a.cls == CLS_CPLX)   ? (ONE_C << sel_a.idx) : '0;
    assign simple_mask_b = (disp_a && sel_a.cls == CLS_SIMPLE) ? (ONE_S << sel_a.idx) : '0;
    assign fp_mask_b     = (disp_a && sel_a.cls == CLS_FP)     ? (ONE_F << sel_a.idx) : '0;

    assign in_ready = ~a_block & ~(pend_b_q & ~disp_b);
    assign capture  = in_valid & in_ready & ~flush;
    assign stall_a  = a_block;
    assign stall_b  = pend_b_q & ~disp_b;

    assign wr_a_en   = disp_a;
    assign wr_b_en   = disp_b;
    assign wr_a_cls  = disp_a ? sel_a.cls : CLS_NONE;
    assign wr_b_cls  = disp_b ? sel_b.cls : CLS_NONE;
    assign wr_a_idx  = disp_a ? sel_a.idx : '0;
    assign wr_b_idx  = disp_b ? sel_b.idx : '0;
    assign wr_a_rob  = disp_a ? tail_q : '0;
    assign wr_b_rob  = disp_b ? (disp_a ? tail_q + TAG_W'(1) : tail_q) : '0;
    assign wr_a_data = disp_a ? data_a_q : '0;
    assign wr_b_data = disp_b ? data_b_q : '0;
    assign rob_tail  = tail_q;
    assign rob_count = count_q;

    always_comb begin
        pend_a_d = pend_a_q & ~disp_a;
        pend_b_d = pend_b_q & ~disp_b;
        head_d   = head_q + TAG_W'(commit_cnt);
        tail_d   = tail_q + TAG_W'(ndisp);
        count_d  = count_q + CNT_W'(ndisp) - CNT_W'(commit_cnt);
        if (capture) begin
            pend_a_d = inst_a_vld & (inst_a_ctrl != CLS_NONE);
            pend_b_d = inst_b_vld & (inst_b_ctrl != CLS_NONE);
        end
        if (flush) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
            count_d  = '0;
            tail_d   = head_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            cls_a_q  <= cls_e'(inst_a_ctrl);
            cls_b_q  <= cls_e'(inst_b_ctrl);
            data_a_q <= inst_a_data;
            data_b_q <= inst_b_data;
        end
    end

    a_commit_legal: assert property (@(posedge clk) disable iff (rst)
        (commit_cnt != 2'd3) && (CNT_W'(commit_cnt) <= count_q));

endmodule
